// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer.
package uart_pkg;

  localparam int UART_WORD_SIZE = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} txq_state_t;

  typedef logic [UART_WORD_SIZE-1:0] uart_word_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; head word is shown on dout.
module uart_sync_fifo #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 16,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop, mem_we;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_we   = do_push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer words and feeds them to the uart transmitter one frame at a time.
//   state     | meaning
//   IDLE      | waiting for a queued word and an idle uart
//   SEND      | send_valid pulse with the head word on data_bits_tx
//   WAIT_BUSY | waiting for the uart to accept (tx_ready low); retry on timeout
//   WAIT_DONE | frame on the line, waiting for tx_ready to return
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WORD_SIZE   = UART_WORD_SIZE,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_valid,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 flush,
  input  logic                 tx_ready,
  output logic                 send_valid,
  output logic [WORD_SIZE-1:0] data_bits_tx,
  output logic [CNT_W-1:0]     count,
  output logic                 empty,
  output logic                 overflow,
  output logic                 ack_err
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  txq_state_t           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 send_valid_q, send_valid_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 overflow_q, overflow_d;
  logic                 ack_err_q, ack_err_d;
  logic                 pop, full;
  logic [WORD_SIZE-1:0] head;

  uart_sync_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_valid),
    .pop   (pop),
    .flush (flush),
    .din   (wr_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign wr_ready     = !full;
  assign send_valid   = send_valid_q;
  assign data_bits_tx = data_q;
  assign overflow     = overflow_q;
  assign ack_err      = ack_err_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    send_valid_d = 1'b0;
    data_d       = data_q;
    pop          = 1'b0;
    ack_err_d    = ack_err_q;
    overflow_d   = overflow_q | (wr_valid & full);
    case (state_q)
      IDLE: begin
        if (!empty && tx_ready) begin
          state_d      = SEND;
          send_valid_d = 1'b1;
          data_d       = head;
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Head stays queued so the same word is offered again.
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d      = IDLE;
      send_valid_d = 1'b0;
      pop          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      send_valid_q <= 1'b0;
      data_q       <= '0;
      overflow_q   <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      send_valid_q <= send_valid_d;
      data_q       <= data_d;
      overflow_q   <= overflow_d;
      ack_err_q    <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: a uart stub consumes send pulses and reports received words to a monitor.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_valid = 1'b0;
  uart_word_t wr_data = '0;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b1;
  logic       wr_ready, send_valid, empty, overflow, ack_err;
  uart_word_t data_bits_tx;
  logic [4:0] count;

  uart_tx_fifo #(.WORD_SIZE(8), .DEPTH(16), .ACK_TIMEOUT(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .tx_ready     (tx_ready),
    .send_valid   (send_valid),
    .data_bits_tx (data_bits_tx),
    .count        (count),
    .empty        (empty),
    .overflow     (overflow),
    .ack_err      (ack_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stub_mode = 0;   // 0 normal uart, 1 never goes busy, 2 held busy
  int         pulse_cnt = 0;
  int         pulse_cyc = 0;
  uart_word_t pulse_data = '0;
  uart_word_t rx_data = '0;
  int         peak = 0;
  int         acc_cyc = 0;
  uart_word_t exp_q [$];
  event       rx_ev;
  uart_word_t burst [10] = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (int'(count) > peak) peak = int'(count);
  end

  initial begin : uart_stub
    bit         busy;
    bit         started;
    int         left;
    uart_word_t shreg;
    busy = 0;
    left = 0;
    shreg = '0;
    forever begin
      @(negedge clk);
      started = 0;
      if (!rstn) begin
        busy = 0;
        tx_ready = 1'b1;
      end else begin
        if (send_valid) begin
          pulse_cnt++;
          pulse_cyc = cyc;
          pulse_data = data_bits_tx;
          if (stub_mode == 0) begin
            chk("send_while_busy", int'(busy), 0);
            if (!busy) begin
              busy = 1;
              started = 1;
              left = FRAME;
              shreg = data_bits_tx;
            end
          end else if (stub_mode == 2) begin
            chk("send_while_blocked", int'(send_valid), 0);
          end
        end
        if (stub_mode == 0) begin
          if (busy && !started) begin
            left--;
            if (left == 0) begin
              busy = 0;
              rx_data = shreg;
              -> rx_ev;
            end
          end
          tx_ready = !busy;
        end else if (stub_mode == 1) begin
          tx_ready = 1'b1;
        end else begin
          tx_ready = 1'b0;
        end
      end
    end
  end

  initial forever begin : monitor
    uart_word_t w;
    @(rx_ev);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rx_unexpected: got %0h expected nothing", rx_data);
    end else begin
      w = exp_q.pop_front();
      chk("rx_data", int'(rx_data), int'(w));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called just after a negedge; leaves wr_valid high for back-to-back use.
  task automatic push(input uart_word_t w, input bit track);
    wr_valid = 1'b1;
    wr_data = w;
    if (track) exp_q.push_back(w);
    tick();
    acc_cyc = cyc;
  endtask

  task automatic wait_pulse(input string name, input int prev, input int max);
    int n;
    n = 0;
    while (pulse_cnt == prev && n < max) begin
      tick();
      n++;
    end
    chk(name, int'(pulse_cnt > prev), 1);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || count != 0 || !tx_ready) && n < max) begin
      tick();
      n++;
    end
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_count_zero"}, int'(count), 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_count"}, int'(count), 0);
    chk({name, "_empty"}, int'(empty), 1);
    chk({name, "_wr_ready"}, int'(wr_ready), 1);
    chk({name, "_send_valid"}, int'(send_valid), 0);
    chk({name, "_data_bits_tx"}, int'(data_bits_tx), 0);
    chk({name, "_overflow"}, int'(overflow), 0);
    chk({name, "_ack_err"}, int'(ack_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, first_cyc, n;
    uart_word_t keep;

    repeat (3) tick();
    check_reset_vals("reset");
    rstn = 1'b1;
    tick();

    // Single word
    p = pulse_cnt;
    push(8'h21, 1);
    wr_valid = 1'b0;
    wait_pulse("single_pulse", p, 20);
    chk("single_latency", pulse_cyc - acc_cyc, 1);
    chk("single_data", int'(pulse_data), 8'h21);
    wait_drain("single", 60);

    // Burst of ten
    peak = 0;
    foreach (burst[i]) push(burst[i], 1);
    wr_valid = 1'b0;
    wait_drain("burst", 400);
    chk("burst_peak", int'(peak == 9 || peak == 10), 1);

    // Fill to depth with the uart held busy, then overflow
    stub_mode = 2;
    tick();
    for (int i = 0; i < 16; i++) push(uart_word_t'(8'h10 + i), 1);
    wr_valid = 1'b0;
    chk("fill_count", int'(count), 16);
    chk("fill_wr_ready", int'(wr_ready), 0);
    chk("fill_overflow_before", int'(overflow), 0);
    push(8'hEE, 0);
    wr_valid = 1'b0;
    chk("fill_overflow_after", int'(overflow), 1);
    chk("fill_count_after_drop", int'(count), 16);
    stub_mode = 0;
    wait_drain("fill", 400);

    // Uart never acknowledges: timeout and retry of the same word
    stub_mode = 1;
    tick();
    p = pulse_cnt;
    push(8'h3C, 0);
    wr_valid = 1'b0;
    wait_pulse("ack_first_pulse", p, 20);
    first_cyc = pulse_cyc;
    chk("ack_first_data", int'(pulse_data), 8'h3C);
    chk("ack_err_before", int'(ack_err), 0);
    p = pulse_cnt;
    wait_pulse("ack_retry_pulse", p, 30);
    chk("ack_retry_spacing", pulse_cyc - first_cyc, 10);
    chk("ack_retry_data", int'(pulse_data), 8'h3C);
    chk("ack_err_after", int'(ack_err), 1);
    chk("ack_count", int'(count), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ack_flush_count", int'(count), 0);
    stub_mode = 0;
    tick();

    // Flush with five words queued behind a frame in flight
    push(8'hA1, 1);
    push(8'hB2, 1);
    push(8'hC3, 1);
    push(8'hD4, 1);
    push(8'hE5, 1);
    push(8'hF6, 1);
    wr_valid = 1'b0;
    n = 0;
    while (!(count == 5 && !tx_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("flush_setup_count", int'(count), 5);
    keep = exp_q[0];
    exp_q.delete();
    exp_q.push_back(keep);
    p = pulse_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_wr_ready", int'(wr_ready), 1);
    chk("flush_overflow_kept", int'(overflow), 1);
    chk("flush_ack_err_kept", int'(ack_err), 1);
    repeat (40) tick();
    chk("flush_no_send", pulse_cnt, p);
    chk("flush_inflight_delivered", exp_q.size(), 0);

    // Asynchronous reset in the middle of a burst
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    push(8'h44, 1);
    push(8'h55, 1);
    wr_valid = 1'b0;
    n = 0;
    while (tx_ready && n < 20) begin
      tick();
      n++;
    end
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("async_reset");
    tick();
    rstn = 1'b1;
    tick();
    p = pulse_cnt;
    push(8'h81, 1);
    wr_valid = 1'b0;
    wait_pulse("post_reset_pulse", p, 20);
    chk("post_reset_latency", pulse_cyc - acc_cyc, 1);
    chk("post_reset_data", int'(pulse_data), 8'h81);
    wait_drain("post_reset", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
